// File: rtl/disp_sched_pkg.sv
// disp_sched_pkg: shared constants, state encoding and width helper for the
// display-source scheduler (disp_sched) and its ms tick prescaler.
package disp_sched_pkg;

   localparam int         NUM_SRC  = 3;
   localparam logic [1:0] SRC_NONE = 2'd3;

   // Per-source slice widths inside the packed req_data / req_pt* buses:
   // source i occupies [i*W +: W].
   localparam int DATA_W = 32;
   localparam int PT_W   = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HOLD = 2'd1,
      ST_FREE = 2'd2
   } disp_state_e;

   // Counter width able to hold 0..max_val; never narrower than one bit so a
   // zero limit still yields a legal vector.
   function automatic int cnt_width(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// ms_tick_gen: 1 ms tick prescaler. Emits a one-cycle pulse every
// CLK_HZ/1000 cycles of Clk; the first pulse follows a full period after reset.
//
// Ports:
//   Clk      in   system clock
//   Reset_n  in   asynchronous reset, active low
//   tick     out  one-cycle pulse per millisecond
module ms_tick_gen
   import disp_sched_pkg::*;
#(
   parameter int CLK_HZ = 50_000_000
) (
   input  logic Clk,
   input  logic Reset_n,
   output logic tick
);

   localparam int               DIV    = (CLK_HZ / 1000 < 1) ? 1 : CLK_HZ / 1000;
   localparam int               CNT_W  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CNT_W-1:0] RELOAD = CNT_W'(DIV - 1);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         cnt <= RELOAD;
      end else if (cnt == '0) begin
         cnt <= RELOAD;
      end else begin
         cnt <= cnt - 1'b1;
      end
   end

   assign tick = (cnt == '0);

endmodule

// File: rtl/disp_sched.sv
// disp_sched: display-source scheduler feeding Disp_Data/point_1/point_2 of
// the display wrapper. Three requesters compete for the display; a newly
// selected source keeps it for at least HOLD_MS ms, and the display blanks
// after IDLE_MS ms without any grant.
//
// Build option: define DISP_RR_EN to arbitrate IDLE/FREE requests round-robin
// starting after the last granted index; otherwise lowest index wins.
//
// Ports:
//   Clk        in   system clock
//   Reset_n    in   asynchronous reset, active low
//   req        in   per-source request, held until granted
//   req_data   in   source i display word at [32i+31:32i]
//   req_pt1    in   source i point_1 at [4i+3:4i]
//   req_pt2    in   source i point_2 at [4i+3:4i]
//   grant      out  one-hot, one-cycle pulse after the capture edge
//   cur_src    out  current owner, 3 = none
//   busy       out  hold timer running
//   Disp_Data  out  registered display word
//   point_1    out  registered decimal-point field 1
//   point_2    out  registered decimal-point field 2
//
// state   | meaning
// --------+------------------------------------------------
// ST_IDLE | no owner, outputs blank
// ST_HOLD | owner set, hold timer running, only owner refreshes
// ST_FREE | owner set, hold expired, idle timer running
module disp_sched
   import disp_sched_pkg::*;
#(
   parameter int                CLK_HZ     = 50_000_000,
   parameter int                HOLD_MS    = 500,
   parameter int                IDLE_MS    = 2000,
   parameter logic [DATA_W-1:0] BLANK_DATA = 32'h0000_0000,
   parameter logic [PT_W-1:0]   BLANK_PT   = 4'd0
) (
   input  logic                        Clk,
   input  logic                        Reset_n,
   input  logic [NUM_SRC-1:0]          req,
   input  logic [NUM_SRC*DATA_W-1:0]   req_data,
   input  logic [NUM_SRC*PT_W-1:0]     req_pt1,
   input  logic [NUM_SRC*PT_W-1:0]     req_pt2,
   output logic [NUM_SRC-1:0]          grant,
   output logic [1:0]                  cur_src,
   output logic                        busy,
   output logic [DATA_W-1:0]           Disp_Data,
   output logic [PT_W-1:0]             point_1,
   output logic [PT_W-1:0]             point_2
);

   localparam int                HOLD_W   = cnt_width(HOLD_MS);
   localparam int                IDLE_W   = cnt_width(IDLE_MS);
   localparam logic [HOLD_W-1:0] HOLD_LD  = HOLD_W'(HOLD_MS);
   localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);
   localparam logic [IDLE_W-1:0] IDLE_LD  = IDLE_W'(IDLE_MS);
   localparam logic [IDLE_W-1:0] IDLE_ONE = IDLE_W'(1);

   logic tick;

   ms_tick_gen #(
      .CLK_HZ (CLK_HZ)
   ) u_tick (
      .Clk     (Clk),
      .Reset_n (Reset_n),
      .tick    (tick)
   );

   disp_state_e         state_q, state_d;
   logic [1:0]          src_q, src_d;
   logic [NUM_SRC-1:0]  grant_q, grant_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic [PT_W-1:0]     pt1_q, pt1_d;
   logic [PT_W-1:0]     pt2_q, pt2_d;
   logic [HOLD_W-1:0]   hold_q, hold_d;
   logic [IDLE_W-1:0]   idle_q, idle_d;

   logic                win_vld;
   logic [1:0]          win_idx;
   logic [NUM_SRC-1:0]  win_oh;
   logic [DATA_W-1:0]   win_data;
   logic [PT_W-1:0]     win_pt1;
   logic [PT_W-1:0]     win_pt2;
   logic                new_src;

`ifdef DISP_RR_EN
   logic [1:0]          last_q, last_d;
   logic [1:0]          cand;
`endif

   // Arbiter. In HOLD only the owner may refresh; elsewhere every requester
   // competes. Loops run from the lowest-preference candidate up so the
   // last assignment is the winner.
   always_comb begin
      win_vld  = 1'b0;
      win_idx  = SRC_NONE;
      win_oh   = '0;
      win_data = '0;
      win_pt1  = '0;
      win_pt2  = '0;
`ifdef DISP_RR_EN
      cand     = 2'd0;
`endif
      if (state_q == ST_HOLD) begin
         for (int i = 0; i < NUM_SRC; i++) begin
            if (src_q == 2'(i) && req[i]) begin
               win_vld  = 1'b1;
               win_idx  = 2'(i);
               win_oh   = '0;
               win_oh[i] = 1'b1;
               win_data = req_data[i*DATA_W +: DATA_W];
               win_pt1  = req_pt1[i*PT_W +: PT_W];
               win_pt2  = req_pt2[i*PT_W +: PT_W];
            end
         end
      end else begin
`ifdef DISP_RR_EN
         for (int k = NUM_SRC - 1; k >= 0; k--) begin
            cand = 2'((int'(last_q) + 1 + k) % NUM_SRC);
            if (req[cand]) begin
               win_vld  = 1'b1;
               win_idx  = cand;
               win_oh   = '0;
               win_oh[cand] = 1'b1;
               win_data = req_data[int'(cand)*DATA_W +: DATA_W];
               win_pt1  = req_pt1[int'(cand)*PT_W +: PT_W];
               win_pt2  = req_pt2[int'(cand)*PT_W +: PT_W];
            end
         end
`else
         for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (req[i]) begin
               win_vld  = 1'b1;
               win_idx  = 2'(i);
               win_oh   = '0;
               win_oh[i] = 1'b1;
               win_data = req_data[i*DATA_W +: DATA_W];
               win_pt1  = req_pt1[i*PT_W +: PT_W];
               win_pt2  = req_pt2[i*PT_W +: PT_W];
            end
         end
`endif
      end
   end

   // Next state. A grant to a different source (or out of IDLE) restarts
   // the hold window and the tick on that edge is not counted. An owner
   // refresh during HOLD still lets the hold timer advance.
   always_comb begin
      state_d = state_q;
      src_d   = src_q;
      grant_d = '0;
      data_d  = data_q;
      pt1_d   = pt1_q;
      pt2_d   = pt2_q;
      hold_d  = hold_q;
      idle_d  = idle_q;
      new_src = win_vld && (state_q == ST_IDLE || win_idx != src_q);
`ifdef DISP_RR_EN
      last_d  = last_q;
`endif

      if (win_vld) begin
         grant_d = win_oh;
         src_d   = win_idx;
         data_d  = win_data;
         pt1_d   = win_pt1;
         pt2_d   = win_pt2;
         idle_d  = IDLE_LD;
`ifdef DISP_RR_EN
         last_d  = win_idx;
`endif
      end

      if (new_src) begin
         if (HOLD_MS == 0) begin
            state_d = ST_FREE;
         end else begin
            state_d = ST_HOLD;
            hold_d  = HOLD_LD;
         end
      end else if (tick) begin
         case (state_q)
            ST_HOLD: begin
               if (hold_q <= HOLD_ONE) begin
                  state_d = ST_FREE;
                  hold_d  = '0;
               end else begin
                  hold_d  = hold_q - 1'b1;
               end
            end
            ST_FREE: begin
               if (!win_vld) begin
                  if (idle_q <= IDLE_ONE) begin
                     state_d = ST_IDLE;
                     src_d   = SRC_NONE;
                     data_d  = BLANK_DATA;
                     pt1_d   = BLANK_PT;
                     pt2_d   = BLANK_PT;
                     idle_d  = '0;
                  end else begin
                     idle_d  = idle_q - 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q <= ST_IDLE;
         src_q   <= SRC_NONE;
         grant_q <= '0;
         data_q  <= BLANK_DATA;
         pt1_q   <= BLANK_PT;
         pt2_q   <= BLANK_PT;
         hold_q  <= '0;
         idle_q  <= '0;
      end else begin
         state_q <= state_d;
         src_q   <= src_d;
         grant_q <= grant_d;
         data_q  <= data_d;
         pt1_q   <= pt1_d;
         pt2_q   <= pt2_d;
         hold_q  <= hold_d;
         idle_q  <= idle_d;
      end
   end

`ifdef DISP_RR_EN
   // Reset value makes the first search start at source 0.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         last_q <= 2'(NUM_SRC - 1);
      end else begin
         last_q <= last_d;
      end
   end
`endif

   assign grant     = grant_q;
   assign cur_src   = src_q;
   assign busy      = (state_q == ST_HOLD);
   assign Disp_Data = data_q;
   assign point_1   = pt1_q;
   assign point_2   = pt2_q;

endmodule

// File: tb/tb_disp_sched.sv
module tb_disp_sched;

   localparam int          CLK_HZ     = 10_000;
   localparam int          HOLD_MS    = 5;
   localparam int          IDLE_MS    = 20;
   localparam int          TICK_DIV   = CLK_HZ / 1000;
   localparam logic [31:0] BLANK_DATA = 32'h0000_0000;
   localparam logic [3:0]  BLANK_PT   = 4'd0;

   logic        Clk = 1'b0;
   logic        Reset_n = 1'b0;
   logic [2:0]  req = '0;
   logic [95:0] req_data = '0;
   logic [11:0] req_pt1 = '0;
   logic [11:0] req_pt2 = '0;
   logic [2:0]  grant;
   logic [1:0]  cur_src;
   logic        busy;
   logic [31:0] Disp_Data;
   logic [3:0]  point_1;
   logic [3:0]  point_2;

   disp_sched #(
      .CLK_HZ     (CLK_HZ),
      .HOLD_MS    (HOLD_MS),
      .IDLE_MS    (IDLE_MS),
      .BLANK_DATA (BLANK_DATA),
      .BLANK_PT   (BLANK_PT)
   ) dut (
      .Clk       (Clk),
      .Reset_n   (Reset_n),
      .req       (req),
      .req_data  (req_data),
      .req_pt1   (req_pt1),
      .req_pt2   (req_pt2),
      .grant     (grant),
      .cur_src   (cur_src),
      .busy      (busy),
      .Disp_Data (Disp_Data),
      .point_1   (point_1),
      .point_2   (point_2)
   );

   always #5 Clk = ~Clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: owner, ms elapsed since the owner took over, ms
   // elapsed in FREE since the last grant, and the displayed values.
   int          edge_n;
   int          m_owner;
   int          m_hold_ms;
   int          m_idle_ms;
   int          m_last;
   logic [2:0]  m_grant;
   logic [31:0] m_data;
   logic [3:0]  m_pt1, m_pt2;

   function automatic int pick(input logic [2:0] r, input int start);
      for (int k = 0; k < 3; k++) begin
         int c;
         c = (start + k) % 3;
         if (r[c]) return c;
      end
      return -1;
   endfunction

   task automatic model_reset();
      edge_n    = 0;
      m_owner   = -1;
      m_hold_ms = 0;
      m_idle_ms = 0;
      m_last    = 2;
      m_grant   = '0;
      m_data    = BLANK_DATA;
      m_pt1     = BLANK_PT;
      m_pt2     = BLANK_PT;
   endtask

   task automatic model_edge();
      bit tick;
      bit in_hold;
      int g;
      edge_n++;
      tick    = (edge_n % TICK_DIV) == 0;
      in_hold = (m_owner >= 0) && (m_hold_ms < HOLD_MS);
      g = -1;
      if (in_hold) begin
         if (req[m_owner]) g = m_owner;
      end else begin
`ifdef DISP_RR_EN
         g = pick(req, (m_last + 1) % 3);
`else
         g = pick(req, 0);
`endif
      end
      m_grant = '0;
      if (g >= 0) begin
         m_grant[g] = 1'b1;
         m_data     = req_data[32*g +: 32];
         m_pt1      = req_pt1[4*g +: 4];
         m_pt2      = req_pt2[4*g +: 4];
         m_idle_ms  = 0;
         m_last     = g;
         if (g != m_owner) begin
            m_owner   = g;
            m_hold_ms = 0;
         end else if (in_hold && tick) begin
            m_hold_ms++;
         end
      end else if (tick && m_owner >= 0) begin
         if (in_hold) begin
            m_hold_ms++;
         end else begin
            m_idle_ms++;
            if (m_idle_ms >= IDLE_MS) begin
               m_owner = -1;
               m_data  = BLANK_DATA;
               m_pt1   = BLANK_PT;
               m_pt2   = BLANK_PT;
            end
         end
      end
   endtask

   task automatic check_model(input string name);
      logic [1:0] e_src;
      logic       e_busy;
      e_src  = (m_owner < 0) ? 2'd3 : 2'(m_owner);
      e_busy = (m_owner >= 0) && (m_hold_ms < HOLD_MS);
      n_checks++;
      if ({grant, cur_src, busy, Disp_Data, point_1, point_2} !==
          {m_grant, e_src, e_busy, m_data, m_pt1, m_pt2}) begin
         n_fail++;
         $display("FAIL %s edge=%0d: got grant=%b src=%0d busy=%b data=%h p1=%h p2=%h, want grant=%b src=%0d busy=%b data=%h p1=%h p2=%h",
                  name, edge_n, grant, cur_src, busy, Disp_Data, point_1, point_2,
                  m_grant, e_src, e_busy, m_data, m_pt1, m_pt2);
      end
   endtask

   task automatic expect_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   task automatic cyc(input string name);
      @(posedge Clk);
      model_edge();
      #1;
      check_model(name);
   endtask

   typedef struct {
      logic [2:0]  req;
      logic [95:0] data;
      logic [11:0] pt1;
      logic [2:0]  exp_grant;
      logic [1:0]  exp_src;
      logic        exp_busy;
      logic [31:0] exp_data;
      logic [3:0]  exp_pt1;
   } vec_t;

   vec_t vecs[4];

   initial begin
      int g1_edge;
      int g0_edge;
      int waited;
      bit seen;

      vecs[0] = '{3'b010, {32'h0, 32'h0001_2345, 32'hAAAA_0000}, {4'd0, 4'd3, 4'd5},
                  3'b010, 2'd1, 1'b1, 32'h0001_2345, 4'd3};
      vecs[1] = '{3'b011, {32'h0, 32'h0001_2346, 32'hAAAA_0000}, {4'd0, 4'd3, 4'd5},
                  3'b010, 2'd1, 1'b1, 32'h0001_2346, 4'd3};
      vecs[2] = '{3'b001, {32'h0, 32'h0001_2346, 32'hAAAA_0000}, {4'd0, 4'd3, 4'd5},
                  3'b000, 2'd1, 1'b1, 32'h0001_2346, 4'd3};
      vecs[3] = '{3'b001, {32'h0, 32'h0001_2346, 32'hAAAA_0000}, {4'd0, 4'd3, 4'd5},
                  3'b000, 2'd1, 1'b1, 32'h0001_2346, 4'd3};

      // Reset and quiet period.
      model_reset();
      #23;
      check_model("reset");
      @(negedge Clk);
      Reset_n = 1'b1;
      for (int c = 0; c < 300; c++) cyc("idle");
      expect_eq("idle_outputs", {grant, cur_src, busy, Disp_Data, point_1, point_2},
                {3'b000, 2'd3, 1'b0, 32'h0, 4'd0, 4'd0});

      // Table: first grant, owner refresh while another source waits.
      g1_edge = 0;
      for (int v = 0; v < 4; v++) begin
         req      = vecs[v].req;
         req_data = vecs[v].data;
         req_pt1  = vecs[v].pt1;
         cyc($sformatf("vec%0d_model", v));
         if (v == 0) g1_edge = edge_n;
         expect_eq($sformatf("vec%0d", v),
                   {grant, cur_src, busy, Disp_Data, point_1},
                   {vecs[v].exp_grant, vecs[v].exp_src, vecs[v].exp_busy,
                    vecs[v].exp_data, vecs[v].exp_pt1});
      end

      // Source 0 waits for the hold to expire.
      seen = 0;
      waited = 0;
      while (!seen && waited < 100) begin
         cyc("wait_hold");
         waited++;
         if (grant[0]) seen = 1;
      end
      expect_eq("grant0_seen", 64'(seen), 64'd1);
      g0_edge = edge_n;
      expect_eq("grant0_delay", 64'(g0_edge - g1_edge), 64'd50);
      expect_eq("grant0_owner", {cur_src, Disp_Data, point_1},
                {2'd0, 32'hAAAA_0000, 4'd5});
      req = 3'b000;

      // No traffic: blanking after the hold plus IDLE_MS ticks.
      seen = 0;
      waited = 0;
      while (!seen && waited < 400) begin
         cyc("wait_blank");
         waited++;
         if (cur_src == 2'd3) seen = 1;
      end
      expect_eq("blank_seen", 64'(seen), 64'd1);
      expect_eq("blank_delay", 64'(edge_n - g0_edge), 64'd249);
      expect_eq("blank_outputs", {busy, Disp_Data, point_1, point_2},
                {1'b0, BLANK_DATA, BLANK_PT, BLANK_PT});

      // Simultaneous requests from IDLE.
      req_data = {32'hC0C0_0002, 32'h0, 32'hC0C0_0000};
      req = 3'b101;
      cyc("simul");
`ifdef DISP_RR_EN
      expect_eq("simul_grant", 64'(grant), 64'(3'b100));
`else
      expect_eq("simul_grant", 64'(grant), 64'(3'b001));
`endif
      req = 3'b000;
      cyc("simul_after");
      cyc("simul_after");
      expect_eq("simul_busy", 64'(busy), 64'd1);

      // Reset mid-hold, then a fresh request from IDLE.
      Reset_n = 1'b0;
      model_reset();
      #2;
      check_model("reset_mid_hold");
      @(negedge Clk);
      Reset_n = 1'b1;
      req_data[95:64] = 32'h2222_7777;
      req_pt2[11:8]   = 4'd9;
      req = 3'b100;
      cyc("after_reset");
      expect_eq("after_reset_grant", {grant, cur_src, busy, Disp_Data, point_2},
                {3'b100, 2'd2, 1'b1, 32'h2222_7777, 4'd9});
      req = 3'b000;

      // Randomized requesters against the model.
      for (int c = 0; c < 4000; c++) begin
         for (int i = 0; i < 3; i++) begin
            if (req[i]) begin
               if (m_grant[i]) begin
                  if ($urandom_range(0, 7) != 0) begin
                     req[i] = 1'b0;
                  end else begin
                     req_data[32*i +: 32] = $urandom;
                     req_pt1[4*i +: 4]    = 4'($urandom);
                  end
               end
            end else begin
               if ($urandom_range(0, 3) == 0) begin
                  req_data[32*i +: 32] = $urandom;
                  req_pt1[4*i +: 4]    = 4'($urandom);
                  req_pt2[4*i +: 4]    = 4'($urandom);
               end
               if ($urandom_range(0, 40) == 0) begin
                  req_data[32*i +: 32] = $urandom;
                  req_pt1[4*i +: 4]    = 4'($urandom);
                  req_pt2[4*i +: 4]    = 4'($urandom);
                  req[i] = 1'b1;
               end
            end
         end
         cyc("random");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/disp_sched.md
Name: disp_sched

Overview:
- Display-source scheduler ahead of the hex8_2 / HC595_Driver display path.
- Arbitrates among 3 requesters, e.g. frequency result, range/overflow status and a message source. Each offers a 32-bit Disp_Data word plus point_1/point_2.
- Each newly selected source owns the display for at least HOLD_MS.
- Blanks the display after IDLE_MS with no traffic.
- Outputs connect directly to Disp_Data, point_1 and point_2 of the display wrapper.

Parameters:
- CLK_HZ, 50_000_000: Clk frequency; sets the 1 ms tick prescaler (CLK_HZ/1000 cycles).
- HOLD_MS, 500: minimum ownership time after a source switch, in ms ticks; 0 means no hold.
- IDLE_MS, 2000: ms ticks with no grant before the display blanks.
- BLANK_DATA, 32'h0000_0000: Disp_Data value when the display is blank.
- BLANK_PT, 4'd0: point_1 and point_2 value when the display is blank.

Ports:
- Clk  in  1  system clock
- Reset_n  in  1  asynchronous reset, active low
- req  in  3  request per source; held high until granted
- req_data  in  96  source i data at [32i+31:32i]
- req_pt1  in  12  source i point_1 at [4i+3:4i]
- req_pt2  in  12  source i point_2 at [4i+3:4i]
- grant  out  3  one-hot, 1-cycle pulse on the capture edge
- cur_src  out  2  current owner index; 2'd3 = none
- busy  out  1  high while the hold timer is running
- Disp_Data  out  32  registered display word
- point_1  out  4  registered decimal-point field 1
- point_2  out  4  registered decimal-point field 2

Behaviour:
- Reset, asynchronous on Reset_n low: state IDLE, Disp_Data=BLANK_DATA, point_1=point_2=BLANK_PT, grant=0, cur_src=3, busy=0, all timers cleared.
- Deasserting Reset_n mid-hold discards the owner; the block restarts in IDLE.
- States:
  - IDLE: no owner.
  - HOLD: owner set, hold timer running.
  - FREE: owner set, hold expired.
- Handshake:
  - Requester drives req[i] with stable data and holds both until grant[i].
  - On the grant edge the block registers Disp_Data/points from slice i and pulses grant[i] for exactly 1 cycle.
  - Latency: req sampled at edge k, outputs and grant valid after edge k.
  - The requester must drop req the cycle after grant or it is regranted; back-to-back refreshes are legal.
- Grant rules:
  - IDLE: any req[i]; winner chosen by arbitration. Go to HOLD with cur_src=i and restart the hold timer, or go to FREE if HOLD_MS=0.
  - HOLD: only req[cur_src] is granted (refresh); the hold timer is NOT restarted. Other requests wait.
  - FREE: any request is granted by arbitration. Same source: stay in FREE. New source: go to HOLD, restart the hold timer, update cur_src.
- Arbitration: fixed priority, lowest index wins. In FREE the owner has no special preference.
- Timers (ms tick from prescaler):
  - Hold counter expires after HOLD_MS ticks: HOLD -> FREE, busy=0.
  - Idle counter is cleared on every grant. After IDLE_MS ticks in FREE with no grant: go to IDLE, load blank outputs, cur_src=3.
  - Idle counting only in FREE.
- Tick granularity: transitions occur on the tick edge; hold duration is within [HOLD_MS-1, HOLD_MS] ms.
- Timer widths: clog2(max ms + 1); no wrap-around; counters saturate at the limit.
- Changes on req_data/req_pt* while req is low are ignored; outputs only change on a grant or on blanking.

Optional Feature:
- Macro DISP_RR_EN.
- Defined: FREE/IDLE arbitration is round-robin, searching from (last granted index + 1) mod 3. HOLD refresh is unchanged.
- Undefined: fixed priority as above.

Decomposition:
- Package disp_sched_pkg:
  - NUM_SRC=3
  - SRC_NONE=2'd3
  - state encoding (IDLE, HOLD, FREE)
  - slice-index helper constants
- Sub-module ms_tick_gen(Clk, Reset_n, tick): 1-cycle pulse every CLK_HZ/1000 cycles.
- The arbiter stays inline.

Test Plan:
- Sim parameters: CLK_HZ=10_000 (tick every 10 cycles), HOLD_MS=5, IDLE_MS=20.
- Reset then idle -> Disp_Data=0, points=0, cur_src=3, busy=0, grant=0 for 300 cycles.
- req[1] with data 32'h0001_2345, pt1=3 -> next edge: grant=3'b010 for 1 cycle, Disp_Data=32'h0001_2345, point_1=3, cur_src=1, busy=1.
- During HOLD: req[0] raised and source 1 refreshes with 32'h0001_2346 -> refresh granted immediately; req[0] waits; grant[0] arrives only after busy falls, roughly 50 cycles after the first grant. Then cur_src=0.
- Simultaneous req[0], req[2] in IDLE -> grant[0] (fixed priority). With DISP_RR_EN and last granted index=0, the same stimulus -> grant[2].
- No requests for 20 ticks in FREE -> outputs return to BLANK_DATA/BLANK_PT, cur_src=3.
- Reset_n pulsed low mid-HOLD, then req[2] -> immediate grant[2] from IDLE.
